// File: rtl/ex_ctrl_seq.sv
// Registered execute-stage control: decodes the type flags into datapath selects and owns the
// branch flush sequence and the memory-wait stall. Define MEM_TIMEOUT_EN to add a MEMWAIT watchdog.
module ex_ctrl_seq #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BrEq_in,
  input  logic       BrLT_in,
  input  logic [3:0] funct_in,
  input  logic [1:0] ALUOp_in,
  input  logic [2:0] ImmSel_in,
  input  logic       R_in,
  input  logic       I_L_in,
  input  logic       I_C_in,
  input  logic       JALR_in,
  input  logic       S_in,
  input  logic       B_in,
  input  logic       LUI_in,
  input  logic       AUIPC_in,
  input  logic       JAL_in,
  input  logic       mem_ready,
  output logic       PCSel,
  output logic       flush,
  output logic       stall,
  output logic       RegWEn,
  output logic       MemEn,
  output logic       MemRW,
  output logic [1:0] WBSel,
  output logic       ASel,
  output logic       BSel,
  output logic       BrUn,
  output logic [3:0] ALUSel,
  output logic [2:0] ImmSel_out,
  output logic       mem_err
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StMemWait = 2'd2
  } state_e;

  state_e     r_state, w_state;
  logic [2:0] r_fcnt, w_fcnt;
  logic       r_pc_sel, w_pc_sel;
  logic       r_flush, w_flush;
  logic       r_stall, w_stall;
  logic       r_reg_wen, w_reg_wen;
  logic       r_mem_en, w_mem_en;
  logic       r_mem_rw, w_mem_rw;
  logic       r_a_sel, w_a_sel;
  logic       r_b_sel, w_b_sel;
  logic       r_br_un, w_br_un;
  logic       r_mem_err, w_mem_err;
  logic [1:0] r_wb_sel, w_wb_sel;
  logic [3:0] r_alu_sel, w_alu_sel;
  logic [2:0] r_imm_sel, w_imm_sel;

  // Resolve overlapping type flags down to a single winner.
  logic w_jal, w_jalr, w_b, w_s, w_il, w_ic, w_r, w_auipc, w_lui;
  always_comb begin
    {w_jal, w_jalr, w_b, w_s, w_il, w_ic, w_r, w_auipc, w_lui} = '0;
    if (JAL_in)        w_jal   = 1'b1;
    else if (JALR_in)  w_jalr  = 1'b1;
    else if (B_in)     w_b     = 1'b1;
    else if (S_in)     w_s     = 1'b1;
    else if (I_L_in)   w_il    = 1'b1;
    else if (I_C_in)   w_ic    = 1'b1;
    else if (R_in)     w_r     = 1'b1;
    else if (AUIPC_in) w_auipc = 1'b1;
    else if (LUI_in)   w_lui   = 1'b1;
  end

  logic       w_taken, w_redirect, w_mem_op;
  logic [3:0] w_alu_dec;
  assign w_taken    = (funct_in[2] ? BrLT_in : BrEq_in) ^ funct_in[0];
  assign w_redirect = w_jal | w_jalr | (w_b & w_taken);
  assign w_mem_op   = w_il | w_s;

  always_comb begin
    w_alu_dec = 4'b0000;
    if (w_lui) begin
      w_alu_dec = 4'b1111;
    end else if (ALUOp_in == 2'b10) begin
      w_alu_dec = funct_in;
    end else if (ALUOp_in == 2'b11) begin
      // Only SRAI keeps inst[30]; other immediates reuse that bit as immediate data.
      w_alu_dec = {funct_in[3] & (funct_in[2:0] == 3'b101), funct_in[2:0]};
    end
  end

  logic w_timeout;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_wcnt, w_wcnt;
  assign w_timeout = (r_wcnt + 8'd1) == 8'(MEM_TIMEOUT);

  always_comb begin
    w_wcnt = r_wcnt + 8'd1;
    if (r_state != StMemWait) w_wcnt = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wcnt <= 8'd0;
    else     r_wcnt <= w_wcnt;
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^8'(MEM_TIMEOUT);
`endif

  always_comb begin
    w_state   = r_state;
    w_fcnt    = r_fcnt;
    w_pc_sel  = 1'b0;
    w_flush   = 1'b0;
    w_stall   = 1'b0;
    w_reg_wen = 1'b0;
    w_mem_en  = 1'b0;
    w_mem_rw  = r_mem_rw;
    w_a_sel   = r_a_sel;
    w_b_sel   = r_b_sel;
    w_br_un   = r_br_un;
    w_wb_sel  = r_wb_sel;
    w_alu_sel = r_alu_sel;
    w_imm_sel = r_imm_sel;
    w_mem_err = r_mem_err;
    unique case (r_state)
      StRun: begin
        w_alu_sel = w_alu_dec;
        w_a_sel   = w_b | w_auipc | w_jal;
        w_b_sel   = ~w_r;
        w_br_un   = funct_in[1];
        w_imm_sel = ImmSel_in;
        w_reg_wen = w_r | w_ic | w_jalr | w_lui | w_auipc | w_jal;
        w_wb_sel  = (w_jal | w_jalr) ? 2'd2 : (w_il ? 2'd0 : 2'd1);
        w_mem_en  = w_mem_op;
        w_mem_rw  = w_s;
        w_stall   = w_mem_op;
        if (w_redirect) begin
          w_pc_sel = 1'b1;
          w_flush  = 1'b1;
          w_fcnt   = 3'(FLUSH_CYCLES);
          w_state  = StFlush;
        end else if (w_mem_op) begin
          w_state = StMemWait;
        end
      end
      StFlush: begin
        w_fcnt  = r_fcnt - 3'd1;
        w_flush = 1'b1;
        if (r_fcnt <= 3'd1) begin
          w_flush = 1'b0;
          w_state = StRun;
        end
      end
      StMemWait: begin
        w_mem_en = 1'b1;
        w_stall  = 1'b1;
        if (mem_ready) begin
          w_mem_en  = 1'b0;
          w_stall   = 1'b0;
          w_reg_wen = ~r_mem_rw;
          w_state   = StRun;
        end else if (w_timeout) begin
          w_mem_en  = 1'b0;
          w_stall   = 1'b0;
          w_mem_err = 1'b1;
          w_state   = StRun;
        end
      end
      default: w_state = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StRun;
      r_fcnt    <= 3'd0;
      r_pc_sel  <= 1'b0;
      r_flush   <= 1'b0;
      r_stall   <= 1'b0;
      r_reg_wen <= 1'b0;
      r_mem_en  <= 1'b0;
      r_mem_rw  <= 1'b0;
      r_a_sel   <= 1'b0;
      r_b_sel   <= 1'b0;
      r_br_un   <= 1'b0;
      r_mem_err <= 1'b0;
      r_wb_sel  <= 2'd0;
      r_alu_sel <= 4'd0;
      r_imm_sel <= 3'd0;
    end else begin
      r_state   <= w_state;
      r_fcnt    <= w_fcnt;
      r_pc_sel  <= w_pc_sel;
      r_flush   <= w_flush;
      r_stall   <= w_stall;
      r_reg_wen <= w_reg_wen;
      r_mem_en  <= w_mem_en;
      r_mem_rw  <= w_mem_rw;
      r_a_sel   <= w_a_sel;
      r_b_sel   <= w_b_sel;
      r_br_un   <= w_br_un;
      r_mem_err <= w_mem_err;
      r_wb_sel  <= w_wb_sel;
      r_alu_sel <= w_alu_sel;
      r_imm_sel <= w_imm_sel;
    end
  end

  assign PCSel      = r_pc_sel;
  assign flush      = r_flush;
  assign stall      = r_stall;
  assign RegWEn     = r_reg_wen;
  assign MemEn      = r_mem_en;
  assign MemRW      = r_mem_rw;
  assign WBSel      = r_wb_sel;
  assign ASel       = r_a_sel;
  assign BSel       = r_b_sel;
  assign BrUn       = r_br_un;
  assign ALUSel     = r_alu_sel;
  assign ImmSel_out = r_imm_sel;
  assign mem_err    = r_mem_err;

endmodule

// File: doc/ex_ctrl_seq.md
Name: ex_ctrl_seq

Overview:
- Sequential control stage directly downstream of the decode pipeline register.
- Consumes the registered decode bundle (branch compare flags, funct, ALUOp, ImmSel, one-hot instruction-type flags).
- Produces registered datapath controls: PC select, ALU select, operand muxes, write-back, memory strobes.
- Owns the control-hazard flush sequence and a memory-wait stall handshake to the upstream stages.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays high after a taken branch or jump; legal range 1..7.
- MEM_TIMEOUT, 15, watchdog limit in cycles for MEMWAIT; used only with the optional feature; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- BrEq_in  in  1  rs1==rs2
- BrLT_in  in  1  rs1<rs2
- funct_in  in  4  {inst[30], funct3}
- ALUOp_in  in  2  00 add, 01 branch, 10 R-type, 11 I-type
- ImmSel_in  in  3  immediate format, passed through
- R_in, I_L_in, I_C_in, JALR_in, S_in, B_in, LUI_in, AUIPC_in, JAL_in  in  1 each  instruction-type flags
- mem_ready  in  1  data memory completion strobe
- PCSel  out  1  1 = redirect PC to ALU result
- flush  out  1  upstream must kill in-flight instructions
- stall  out  1  upstream must hold its registers
- RegWEn  out  1  register-file write enable
- MemEn  out  1  data memory access strobe
- MemRW  out  1  1 = store
- WBSel  out  2  0 mem, 1 ALU, 2 PC+4
- ASel  out  1  1 = PC
- BSel  out  1  1 = immediate
- BrUn  out  1  unsigned compare
- ALUSel  out  4  ALU operation
- ImmSel_out  out  3  registered ImmSel_in
- mem_err  out  1  sticky watchdog error

Behaviour:
- Every output is a register updated on the clk rising edge. Latency is 1 cycle from input to output.
- Reset: all outputs 0, state RUN, counters 0. Reset asserted mid-operation aborts MEMWAIT or FLUSH immediately.
- Type priority when more than one flag is set: JAL > JALR > B > S > I_L > I_C > R > AUIPC > LUI.
- No flag set: bubble. All enables and PCSel are 0.
- Decode in RUN:
  - ALUSel:
    - LUI: 4'b1111 (pass B), regardless of ALUOp.
    - ALUOp 00 or 01: 4'b0000 (add).
    - ALUOp 10: funct_in.
    - ALUOp 11: {funct_in[3] & (funct_in[2:0]==3'b101), funct_in[2:0]}.
  - ASel = B | AUIPC | JAL.
  - BSel = ~R.
  - RegWEn = R | I_C | JALR | LUI | AUIPC | JAL. Loads write later; see MEMWAIT.
  - WBSel: 2 for JAL/JALR, 0 for I_L, 1 otherwise.
  - BrUn = funct_in[1].
  - Branch taken = (funct_in[2] ? BrLT_in : BrEq_in) XOR funct_in[0].
- FSM states RUN, FLUSH, MEMWAIT.
- RUN:
  - Taken B, JAL or JALR: PCSel=1 for exactly one cycle, flush=1, load flush counter with FLUSH_CYCLES, go to FLUSH.
  - I_L or S: MemEn=1, MemRW=S, stall=1, go to MEMWAIT.
  - Otherwise stay in RUN.
- FLUSH:
  - Inputs ignored.
  - RegWEn, MemEn and PCSel forced 0; flush=1.
  - Counter decrements each cycle; on the edge where it reaches 0, flush=0 and state returns to RUN.
  - flush is high for exactly FLUSH_CYCLES cycles.
- MEMWAIT:
  - MemEn, MemRW, WBSel and ALUSel held stable; stall=1.
  - Upstream holds the next instruction at the inputs.
  - Edge with mem_ready=1: MemEn=0, stall=0, RegWEn=1 for one cycle if the access was a load, state RUN.
  - The held instruction is consumed on the following edge.
- mem_ready outside MEMWAIT is ignored.
- mem_err is cleared only by rst.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on MEMWAIT entry and increments each MEMWAIT cycle.
  - When the count reaches MEM_TIMEOUT without mem_ready, the access aborts: MemEn=0, stall=0, RegWEn=0, mem_err=1 (sticky), state RUN.
  - mem_ready on the timeout edge wins: normal completion, no error.
- Undefined: no counter; MEMWAIT waits indefinitely; mem_err is tied 0.

Test Plan:
- rst pulse asserted asynchronously mid-FLUSH -> all outputs 0 immediately; first post-reset input decoded normally.
- R-type, funct_in=4'b1000, ALUOp=10 -> next cycle ALUSel=1000, RegWEn=1, BSel=0, WBSel=1, PCSel=0.
- B with funct_in=3'b001 (BNE), BrEq_in=0 -> PCSel=1 for 1 cycle; flush=1 for 2 cycles; inputs during flush produce RegWEn=0; BrEq_in=1 gives no redirect.
- JAL and S asserted together -> JAL wins: WBSel=2, RegWEn=1, ASel=1, MemEn=0, FLUSH entered.
- Load, mem_ready held low 3 cycles then high -> stall=1 for 4 cycles, MemEn stable; then RegWEn=1 for 1 cycle, WBSel=0.
- With MEM_TIMEOUT_EN and MEM_TIMEOUT=4: store, mem_ready never asserted -> abort after 4 cycles, mem_err=1 until rst; without the macro, stall stays 1.
